// File: rtl/segre_pkg.sv
// Shared types and constants for the segre core.
// Store-buffer entry layout and byte-mask helpers live here too.
package segre_pkg;

    localparam int ADDR_SIZE      = 32;
    localparam int NUM_SB_ENTRIES = 4;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic [31:0]          data;
        memop_data_type_e     data_type;
        logic [3:0]           mask;
    } sb_entry_t;

    localparam int SB_ENTRY_BITS = $bits(sb_entry_t);

    function automatic logic [3:0] sb_byte_mask(
        input logic [1:0]       off,
        input memop_data_type_e t
    );
        logic [3:0] m;
        case (t)
            BYTE:    m = 4'b0001 << off;
            HALF:    m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] sb_data_mask(input memop_data_type_e t);
        logic [31:0] m;
        case (t)
            BYTE:    m = 32'h0000_00ff;
            HALF:    m = 32'h0000_ffff;
            default: m = 32'hffff_ffff;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/segre_store_buffer.sv
// Store buffer: circular FIFO of committed stores with load lookup.
// Define SEGRE_SB_FORWARD_EN to forward data; otherwise any overlap stalls.
module segre_store_buffer
    import segre_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_SB_ENTRIES,
    parameter int ADDR_W      = ADDR_SIZE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              store_valid_i,
    input  logic [ADDR_W-1:0] store_addr_i,
    input  logic [31:0]       store_data_i,
    input  logic [1:0]        store_type_i,
    output logic              full_o,
    output logic              empty_o,
    input  logic              load_valid_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [1:0]        load_type_i,
    output logic              load_hit_o,
    output logic [31:0]       load_data_o,
    output logic              load_conflict_o,
    output logic              drain_valid_o,
    output logic [ADDR_W-1:0] drain_addr_o,
    output logic [31:0]       drain_data_o,
    output logic [1:0]        drain_type_o,
    input  logic              drain_ready_i
);

    localparam int PTR_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t                entries_q [NUM_ENTRIES];
    sb_entry_t                entries_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;

    logic                     push;
    logic                     pop;
    memop_data_type_e         st_type;
    memop_data_type_e         ld_type;
    sb_entry_t                head_e;

    assign st_type = memop_data_type_e'(store_type_i);
    assign ld_type = memop_data_type_e'(load_type_i);

    assign full_o  = (count_q == CNT_W'(NUM_ENTRIES));
    assign empty_o = (count_q == '0);

    // A full buffer rejects a push even when a pop frees a slot this cycle.
    assign push = store_valid_i && !full_o;
    assign pop  = !empty_o && drain_ready_i;

    always_comb begin
        entries_d = entries_q;
        valid_d   = valid_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (push) begin
            entries_d[tail_q].addr      = ADDR_SIZE'(store_addr_i);
            entries_d[tail_q].data      = store_data_i;
            entries_d[tail_q].data_type = st_type;
            entries_d[tail_q].mask      = sb_byte_mask(store_addr_i[1:0], st_type);
            valid_d[tail_q]             = 1'b1;
            tail_d                      = tail_q + 1'b1;
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries_q[i] <= entries_d[i];
            end
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_e        = entries_q[head_q];
    assign drain_valid_o = !empty_o;
    assign drain_addr_o  = drain_valid_o ? head_e.addr[ADDR_W-1:0] : '0;
    assign drain_data_o  = drain_valid_o ? head_e.data : '0;
    assign drain_type_o  = drain_valid_o ? head_e.data_type : 2'b00;

    logic [3:0]       ld_mask;
    logic             match;
    logic [PTR_W-1:0] idx;
`ifdef SEGRE_SB_FORWARD_EN
    logic [PTR_W-1:0] sel;
    sb_entry_t        sel_e;
    logic [1:0]       shift;
    logic             subset;
`endif

    assign ld_mask = sb_byte_mask(load_addr_i[1:0], ld_type);

    // Walk oldest to youngest; the last match seen is the youngest.
    always_comb begin
        match = 1'b0;
        idx   = '0;
`ifdef SEGRE_SB_FORWARD_EN
        sel   = '0;
`endif
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            idx = head_q + PTR_W'(k);
            if (valid_q[idx] &&
                entries_q[idx].addr[ADDR_W-1:2] == load_addr_i[ADDR_W-1:2] &&
                |(entries_q[idx].mask & ld_mask)) begin
                match = 1'b1;
`ifdef SEGRE_SB_FORWARD_EN
                sel   = idx;
`endif
            end
        end
    end

`ifdef SEGRE_SB_FORWARD_EN
    assign sel_e  = entries_q[sel];
    assign shift  = load_addr_i[1:0] - sel_e.addr[1:0];
    assign subset = ((ld_mask & ~sel_e.mask) == 4'b0000);

    always_comb begin
        load_hit_o      = load_valid_i && match && subset;
        load_conflict_o = load_valid_i && match && !subset;
        load_data_o     = '0;
        if (load_hit_o) begin
            load_data_o = (sel_e.data >> {shift, 3'b000}) & sb_data_mask(ld_type);
        end
    end
`else
    assign load_hit_o      = 1'b0;
    assign load_data_o     = '0;
    assign load_conflict_o = load_valid_i && match;
`endif

endmodule
